demux_store: RTL and testbench
==============================

DEMUX_STORE -- requirements
Module: demux_store

Interface
REQ-001 SHALL provide parameter DW, default 2: data width of each slot.
REQ-002 SHALL provide clk  input  1: single clock, all state updates on rising edge.
REQ-003 SHALL provide reset  input  1: asynchronous, active-high reset.
REQ-004 SHALL provide wr_en  input  1: write request for this cycle.
REQ-005 SHALL provide wr_sel  input  5: manual write slot index; legal range 0-30.
REQ-006 SHALL provide wr_data  input  DW: data to store in the selected slot.
REQ-007 SHALL provide auto_mode  input  1: 1 = write index comes from internal wr_ptr; 0 = write index comes from wr_sel.
REQ-008 SHALL provide rd_en  input  1: consume request for this cycle.
REQ-009 SHALL provide rd_sel  input  5: slot index to consume; legal range 0-30.
REQ-010 SHALL provide clr_flags  input  1: clears the sticky flags ovf and sel_err.
REQ-011 SHALL provide out_data  output  31*DW: slot k occupies bits [k*DW+DW-1 : k*DW]; registered.
REQ-012 SHALL provide out_valid  output  31: bit k = 1 when slot k holds unconsumed data; registered.
REQ-013 SHALL provide wr_ptr  output  5: auto-mode write pointer; registered.
REQ-014 SHALL provide valid_cnt  output  6: number of set out_valid bits; registered.
REQ-015 SHALL provide full  output  1: combinational, (valid_cnt == 31).
REQ-016 SHALL provide ovf  output  1: sticky flag, set when a write overwrites an unconsumed slot.
REQ-017 SHALL provide sel_err  output  1: sticky flag, set on any access to index 31.

Function
REQ-018 SHALL compute the write index widx as auto_mode ? wr_ptr : wr_sel.
REQ-019 SHALL, on wr_en with widx in 0-30, load wr_data into slot widx and set out_valid[widx]; both are visible one cycle after the edge.
REQ-020 SHALL, on wr_en with widx = 31, store nothing, leave wr_ptr unchanged and set sel_err.
REQ-021 SHALL, on a write to a slot that is already valid, overwrite its data, keep it valid, leave valid_cnt unchanged and set ovf.
REQ-022 SHALL, on rd_en with rd_sel in 0-30 and the slot valid, clear out_valid[rd_sel]; out_data of that slot is retained.
REQ-023 SHALL treat rd_en to an invalid slot as a no-op; no flag is set.
REQ-024 SHALL, on rd_en with rd_sel = 31, set sel_err and change no slot.
REQ-025 SHALL, when a read and a write target the same valid slot in one cycle, store the new data, keep the slot valid, leave valid_cnt unchanged and not set ovf.
REQ-026 SHALL, when a read and a write target different slots in one cycle, perform both operations, with valid_cnt changing by the net amount.
REQ-027 SHALL, in auto_mode, increment wr_ptr by 1 on each accepted write and wrap 30 -> 0; wr_ptr SHALL never hold 31.
REQ-028 SHALL hold wr_ptr when auto_mode = 0; switching mode SHALL take effect on the same cycle with no reload.
REQ-029 SHALL keep writing when full: a write then overwrites per REQ-021; the block has no backpressure.
REQ-030 SHALL clear ovf and sel_err on clr_flags; if a setting event occurs in the same cycle, set wins.
REQ-031 SHALL update valid_cnt incrementally: +1 for a write to an invalid slot, -1 for a consume of a valid slot, net when both occur.

Reset
REQ-032 SHALL, while reset = 1, immediately force out_data, out_valid, wr_ptr, valid_cnt, ovf and sel_err to 0, independent of clk.
REQ-033 SHALL, on reset asserted mid-operation, discard all stored data and flags; the first write after deassertion goes to slot 0 in auto mode.

Verification
REQ-034 SHALL cover: manual mode, wr_sel=5, wr_data=2'b10 -> next cycle out_data[11:10]=2'b10, out_valid=31'h20, valid_cnt=1.
REQ-035 SHALL cover: auto mode, 32 writes of data=i%4 -> slots 0-30 filled, full=1, the 32nd write overwrites slot 0 with ovf=1, final wr_ptr=1.
REQ-036 SHALL cover: wr_sel=31 write and rd_sel=31 read -> no slot change, sel_err=1; then clr_flags -> sel_err=0.
REQ-037 SHALL cover: slot 3 valid; rd_en and wr_en both to slot 3 with data 2'b01 -> out_valid[3]=1, ovf=0, valid_cnt unchanged.
REQ-038 SHALL cover: 10 slots valid, reset pulsed between clock edges -> all outputs 0 before the next edge.
REQ-039 SHALL cover: rd_en to empty slot 7 concurrently with a write to slot 8 -> out_valid=31'h100, valid_cnt=1, no flags set.

Source files
------------

// File: rtl/demux_store.sv
// demux_store: 31-slot demultiplexing store with per-slot valid bits.
//
// A write lands in the slot chosen either by the caller (wr_sel_i) or by an
// internal auto-incrementing pointer (wr_ptr_o). A read consumes a slot by
// clearing its valid bit while keeping its data. Index 31 is illegal on both
// sides and raises the sticky sel_err_o flag. Overwriting an unconsumed slot
// raises the sticky ovf_o flag. There is no backpressure.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      asynchronous active-high reset
//   wr_en_i      write request this cycle
//   wr_sel_i     manual write slot index (0-30 legal)
//   wr_data_i    write data
//   auto_mode_i  1: write index from wr_ptr_o, 0: from wr_sel_i
//   rd_en_i      consume request this cycle
//   rd_sel_i     slot index to consume (0-30 legal)
//   clr_flags_i  clear ovf_o and sel_err_o (a same-cycle set wins)
//   out_data_o   slot k at [k*DW +: DW], registered
//   out_valid_o  bit k set while slot k holds unconsumed data, registered
//   wr_ptr_o     auto-mode write pointer, registered, never 31
//   valid_cnt_o  population count of out_valid_o, registered
//   full_o       valid_cnt_o == 31
//   ovf_o        sticky overwrite flag
//   sel_err_o    sticky illegal-index flag
module demux_store #(
   parameter int unsigned DW = 2
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_en_i,
   input  logic [4:0]        wr_sel_i,
   input  logic [DW-1:0]     wr_data_i,
   input  logic              auto_mode_i,
   input  logic              rd_en_i,
   input  logic [4:0]        rd_sel_i,
   input  logic              clr_flags_i,
   output logic [31*DW-1:0]  out_data_o,
   output logic [30:0]       out_valid_o,
   output logic [4:0]        wr_ptr_o,
   output logic [5:0]        valid_cnt_o,
   output logic              full_o,
   output logic              ovf_o,
   output logic              sel_err_o
);

   localparam int unsigned NumSlots = 31;
   localparam logic [4:0]  BadIdx   = 5'd31;
   localparam logic [4:0]  LastIdx  = 5'd30;

   logic [31*DW-1:0] data_q, data_d;
   logic [30:0]      valid_q, valid_d;
   logic [4:0]       wr_ptr_q, wr_ptr_d;
   logic [5:0]       valid_cnt_q, valid_cnt_d;
   logic             ovf_q, ovf_d;
   logic             sel_err_q, sel_err_d;

   logic [4:0]       widx;
   logic [31:0]      valid_ext;   // padded so index 31 reads as invalid
   logic             wr_ok;
   logic             wr_hit;      // write target already holds unconsumed data
   logic             rd_ok;       // legal consume of a valid slot
   logic             same_slot;   // read and write hit the same valid slot
   logic             cnt_inc;
   logic             cnt_dec;
   logic             set_ovf;
   logic             set_sel_err;

   always_comb begin
      widx        = auto_mode_i ? wr_ptr_q : wr_sel_i;
      valid_ext   = {1'b0, valid_q};
      wr_ok       = wr_en_i && (widx != BadIdx);
      wr_hit      = wr_ok && valid_ext[widx];
      rd_ok       = rd_en_i && (rd_sel_i != BadIdx) && valid_ext[rd_sel_i];
      same_slot   = wr_ok && rd_ok && (widx == rd_sel_i);

      // A same-slot read+write is a refill, not an overwrite of live data.
      cnt_inc     = wr_ok && !wr_hit;
      cnt_dec     = rd_ok && !same_slot;
      set_ovf     = wr_hit && !same_slot;
      set_sel_err = (wr_en_i && (widx == BadIdx)) || (rd_en_i && (rd_sel_i == BadIdx));
   end

   // Slot data and valid bits. The write is applied after the read so that a
   // same-slot read+write leaves the slot valid.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      for (int unsigned k = 0; k < NumSlots; k++) begin
         if (rd_ok && (rd_sel_i == 5'(k))) begin
            valid_d[k] = 1'b0;
         end
         if (wr_ok && (widx == 5'(k))) begin
            valid_d[k]         = 1'b1;
            data_d[k*DW +: DW] = wr_data_i;
         end
      end
   end

   always_comb begin
      valid_cnt_d = valid_cnt_q;
      unique case ({cnt_inc, cnt_dec})
         2'b10:   valid_cnt_d = valid_cnt_q + 6'd1;
         2'b01:   valid_cnt_d = valid_cnt_q - 6'd1;
         default: valid_cnt_d = valid_cnt_q;
      endcase
   end

   // Pointer only advances on an accepted auto-mode write and wraps 30 -> 0.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (auto_mode_i && wr_ok) begin
         wr_ptr_d = (wr_ptr_q == LastIdx) ? 5'd0 : wr_ptr_q + 5'd1;
      end
   end

   // Sticky flags: clear first, then a same-cycle set takes precedence.
   always_comb begin
      ovf_d     = clr_flags_i ? 1'b0 : ovf_q;
      sel_err_d = clr_flags_i ? 1'b0 : sel_err_q;
      if (set_ovf) begin
         ovf_d = 1'b1;
      end
      if (set_sel_err) begin
         sel_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         data_q      <= '0;
         valid_q     <= '0;
         wr_ptr_q    <= '0;
         valid_cnt_q <= '0;
         ovf_q       <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         data_q      <= data_d;
         valid_q     <= valid_d;
         wr_ptr_q    <= wr_ptr_d;
         valid_cnt_q <= valid_cnt_d;
         ovf_q       <= ovf_d;
         sel_err_q   <= sel_err_d;
      end
   end

   assign out_data_o  = data_q;
   assign out_valid_o = valid_q;
   assign wr_ptr_o    = wr_ptr_q;
   assign valid_cnt_o = valid_cnt_q;
   assign full_o      = (valid_cnt_q == 6'd31);
   assign ovf_o       = ovf_q;
   assign sel_err_o   = sel_err_q;

endmodule

// File: tb/tb_demux_store.sv
// tb_demux_store: scoreboard bench for demux_store. Each driven cycle pushes
// the reference model's predicted outputs; after the clock edge the entry is
// popped and compared against the DUT.
module tb_demux_store;

   localparam int unsigned DW = 2;

   typedef struct {
      logic [31*DW-1:0] data;
      logic [30:0]      valid;
      logic [4:0]       ptr;
      logic [5:0]       cnt;
      logic             full;
      logic             ovf;
      logic             sel_err;
   } exp_t;

   logic              clk;
   logic              reset;
   logic              wr_en;
   logic [4:0]        wr_sel;
   logic [DW-1:0]     wr_data;
   logic              auto_mode;
   logic              rd_en;
   logic [4:0]        rd_sel;
   logic              clr_flags;
   logic [31*DW-1:0]  out_data;
   logic [30:0]       out_valid;
   logic [4:0]        wr_ptr;
   logic [5:0]        valid_cnt;
   logic              full;
   logic              ovf;
   logic              sel_err;

   int n_chk = 0;
   int n_err = 0;

   exp_t sb_q[$];

   // Reference model state
   logic [31*DW-1:0] m_data;
   logic [30:0]      m_valid;
   logic [4:0]       m_ptr;
   int               m_cnt;
   logic             m_ovf;
   logic             m_sel_err;

   demux_store #(.DW(DW)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .wr_en_i     (wr_en),
      .wr_sel_i    (wr_sel),
      .wr_data_i   (wr_data),
      .auto_mode_i (auto_mode),
      .rd_en_i     (rd_en),
      .rd_sel_i    (rd_sel),
      .clr_flags_i (clr_flags),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .wr_ptr_o    (wr_ptr),
      .valid_cnt_o (valid_cnt),
      .full_o      (full),
      .ovf_o       (ovf),
      .sel_err_o   (sel_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_data    = '0;
      m_valid   = '0;
      m_ptr     = '0;
      m_cnt     = 0;
      m_ovf     = 1'b0;
      m_sel_err = 1'b0;
   endtask

   // Sequential reference: flags judged on pre-cycle state, then read, then write.
   task automatic model_step(input logic en, input logic [4:0] sel, input logic [DW-1:0] d,
                             input logic am, input logic ren, input logic [4:0] rsel,
                             input logic clr);
      logic [4:0] w;
      logic       rd_live;
      logic       s_ovf;
      logic       s_err;
      w       = am ? m_ptr : sel;
      rd_live = 1'b0;
      s_ovf   = 1'b0;
      s_err   = 1'b0;
      if (ren) begin
         if (rsel == 5'd31) s_err = 1'b1;
         else if (m_valid[rsel]) rd_live = 1'b1;
      end
      if (en) begin
         if (w == 5'd31) s_err = 1'b1;
         else if (m_valid[w] && !(rd_live && rsel == w)) s_ovf = 1'b1;
      end
      if (rd_live) begin
         m_valid[rsel] = 1'b0;
         m_cnt--;
      end
      if (en && w != 5'd31) begin
         if (!m_valid[w]) m_cnt++;
         m_valid[w]         = 1'b1;
         m_data[w*DW +: DW] = d;
         if (am) m_ptr = (m_ptr == 5'd30) ? 5'd0 : m_ptr + 5'd1;
      end
      if (clr) begin
         m_ovf     = 1'b0;
         m_sel_err = 1'b0;
      end
      if (s_ovf) m_ovf = 1'b1;
      if (s_err) m_sel_err = 1'b1;
   endtask

   task automatic compare_top(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq({tag, ".sb_empty"}, 64'd1, 64'd0);
         return;
      end
      e = sb_q.pop_front();
      check_eq({tag, ".data"},    64'(out_data),  64'(e.data));
      check_eq({tag, ".valid"},   64'(out_valid), 64'(e.valid));
      check_eq({tag, ".ptr"},     64'(wr_ptr),    64'(e.ptr));
      check_eq({tag, ".cnt"},     64'(valid_cnt), 64'(e.cnt));
      check_eq({tag, ".full"},    64'(full),      64'(e.full));
      check_eq({tag, ".ovf"},     64'(ovf),       64'(e.ovf));
      check_eq({tag, ".sel_err"}, 64'(sel_err),   64'(e.sel_err));
   endtask

   // Drive one cycle (called just after a rising edge), predict, then compare.
   task automatic step(input string tag, input logic en, input logic [4:0] sel,
                       input logic [DW-1:0] d, input logic am, input logic ren,
                       input logic [4:0] rsel, input logic clr);
      exp_t e;
      wr_en     = en;
      wr_sel    = sel;
      wr_data   = d;
      auto_mode = am;
      rd_en     = ren;
      rd_sel    = rsel;
      clr_flags = clr;
      model_step(en, sel, d, am, ren, rsel, clr);
      e.data    = m_data;
      e.valid   = m_valid;
      e.ptr     = m_ptr;
      e.cnt     = 6'(m_cnt);
      e.full    = (m_cnt == 31);
      e.ovf     = m_ovf;
      e.sel_err = m_sel_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      compare_top(tag);
   endtask

   task automatic idle_inputs();
      wr_en     = 1'b0;
      wr_sel    = '0;
      wr_data   = '0;
      auto_mode = 1'b0;
      rd_en     = 1'b0;
      rd_sel    = '0;
      clr_flags = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, ".data"},    64'(out_data),  64'd0);
      check_eq({tag, ".valid"},   64'(out_valid), 64'd0);
      check_eq({tag, ".ptr"},     64'(wr_ptr),    64'd0);
      check_eq({tag, ".cnt"},     64'(valid_cnt), 64'd0);
      check_eq({tag, ".ovf"},     64'(ovf),       64'd0);
      check_eq({tag, ".sel_err"}, 64'(sel_err),   64'd0);
   endtask

   // Synchronous-looking reset pulse, entered and left just after an edge.
   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      idle_inputs();
      model_reset();
      reset = 1'b1;
      #2;
      check_all_zero("por");
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_all_zero("post_reset");

      // Manual write, slot 5
      step("man_w5", 1'b1, 5'd5, 2'b10, 1'b0, 1'b0, 5'd0, 1'b0);
      check_eq("man_w5.slice", 64'(out_data[11:10]), 64'h2);
      check_eq("man_w5.valid_lit", 64'(out_valid), 64'h20);
      check_eq("man_w5.cnt_lit", 64'(valid_cnt), 64'd1);

      // Auto fill: 32 writes, wrap and overwrite slot 0
      do_reset();
      for (int i = 0; i < 32; i++) begin
         step($sformatf("auto_w%0d", i), 1'b1, 5'd0, DW'(i % 4), 1'b1, 1'b0, 5'd0, 1'b0);
         if (i == 30) begin
            check_eq("auto.full_lit", 64'(full), 64'd1);
            check_eq("auto.ptr_wrap", 64'(wr_ptr), 64'd0);
         end
      end
      check_eq("auto.ovf_lit", 64'(ovf), 64'd1);
      check_eq("auto.ptr_lit", 64'(wr_ptr), 64'd1);
      check_eq("auto.slot0", 64'(out_data[1:0]), 64'd3);

      // Illegal index 31 on both sides, then clear
      step("clr0", 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1);
      step("w31", 1'b1, 5'd31, 2'b11, 1'b0, 1'b0, 5'd0, 1'b0);
      check_eq("w31.err_lit", 64'(sel_err), 64'd1);
      step("r31", 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd31, 1'b0);
      step("clr1", 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1);
      check_eq("clr1.err_lit", 64'(sel_err), 64'd0);
      // Set wins over clear in the same cycle
      step("clr_vs_set", 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd31, 1'b1);

      // Same-slot read + write on a valid slot
      do_reset();
      step("w3", 1'b1, 5'd3, 2'b11, 1'b0, 1'b0, 5'd0, 1'b0);
      step("rw3", 1'b1, 5'd3, 2'b01, 1'b0, 1'b1, 5'd3, 1'b0);
      check_eq("rw3.v3_lit", 64'(out_valid[3]), 64'd1);
      check_eq("rw3.ovf_lit", 64'(ovf), 64'd0);

      // Read of empty slot 7 alongside write to slot 8
      do_reset();
      step("r7w8", 1'b1, 5'd8, 2'b10, 1'b0, 1'b1, 5'd7, 1'b0);
      check_eq("r7w8.valid_lit", 64'(out_valid), 64'h100);
      check_eq("r7w8.flags_lit", 64'({ovf, sel_err}), 64'd0);

      // Random mix, including mode switching and both illegal indices
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
              DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 9) == 0));
      end

      // Reset asserted between edges with 10 slots valid
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step($sformatf("pre_rst%0d", i), 1'b1, 5'd0, 2'b01, 1'b1, 1'b0, 5'd0, 1'b0);
      end
      check_eq("pre_rst.cnt_lit", 64'(valid_cnt), 64'd10);
      idle_inputs();
      #3;
      reset = 1'b1;
      #1;
      check_all_zero("mid_rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      check_all_zero("rst_hold");
      step("first_auto", 1'b1, 5'd9, 2'b11, 1'b1, 1'b0, 5'd0, 1'b0);
      check_eq("first_auto.valid_lit", 64'(out_valid), 64'h1);

      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // Watchdog so the bench always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      n_err++;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "timeout");
   end

endmodule
